// File: rtl/bfp_pkg.sv
// bfp_pkg: shared FSM state encoding and block-exponent width for the BFP stage controller
package bfp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;
  localparam int BFP_EXP_W = 8;
endpackage

// File: rtl/bfp_stage_ctrl_if.sv
// bfp_stage_ctrl_if: stage-control bus between the FFT datapath and the BFP controller (abort under BFP_STAGE_CTRL_ABORT_EN)
interface bfp_stage_ctrl_if #(
  parameter int FFT_BFPDW = 5,
  parameter int FFT_N = 10
);
  localparam int SW = FFT_N > 1 ? $clog2(FFT_N) : 1;
  logic start;
  logic stage_done;
  logic bw_act;
  logic [FFT_BFPDW-1:0] bw;
  logic busy;
  logic [SW-1:0] stage_idx;
  logic [FFT_BFPDW-1:0] shift;
  logic shift_vld;
  logic [7:0] bfp_exp;
  logic done;
`ifdef BFP_STAGE_CTRL_ABORT_EN
  logic abort;
  modport master (output start, stage_done, bw_act, bw, abort, input busy, stage_idx, shift, shift_vld, bfp_exp, done);
  modport slave (input start, stage_done, bw_act, bw, abort, output busy, stage_idx, shift, shift_vld, bfp_exp, done);
`else
  modport master (output start, stage_done, bw_act, bw, input busy, stage_idx, shift, shift_vld, bfp_exp, done);
  modport slave (input start, stage_done, bw_act, bw, output busy, stage_idx, shift, shift_vld, bfp_exp, done);
`endif
endinterface

// File: rtl/bfp_peak_track.sv
// bfp_peak_track: running-max register; clear alone zeroes it, clear with update loads the sample
module bfp_peak_track #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         upd,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // track the largest sample seen since the last clear
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (clr) q <= upd ? d : '0;
    else if (upd && d > q) q <= d;
endmodule

// File: rtl/bfp_stage_ctrl.sv
// bfp_stage_ctrl: per-stage block-floating-point shift and exponent controller (optional abort via BFP_STAGE_CTRL_ABORT_EN)
module bfp_stage_ctrl
  import bfp_pkg::*;
#(
  parameter int FFT_BFPDW = 5,
  parameter int FFT_DW = 16,
  parameter int FFT_N = 10,
  parameter int HEADROOM_BW = FFT_DW - 2,
  parameter int MAX_SHIFT = 2
) (
  input logic clk,
  input logic rst,
  bfp_stage_ctrl_if.slave bus
);
  localparam int SW = FFT_N > 1 ? $clog2(FFT_N) : 1;
  localparam logic [FFT_BFPDW-1:0] HR = FFT_BFPDW'(HEADROOM_BW);
  localparam logic [FFT_BFPDW-1:0] MS = FFT_BFPDW'(MAX_SHIFT);
  localparam logic [SW-1:0] LAST = SW'(FFT_N - 1);
  state_t state, state_nxt;
  logic [SW-1:0] stage_idx;
  logic [FFT_BFPDW-1:0] peak, peak_eff, diff, shift, shift_nxt;
  logic [BFP_EXP_W-1:0] bfp_exp;
  logic [BFP_EXP_W:0] exp_sum;
  logic abort_hit, run_end, clr, upd;
`ifdef BFP_STAGE_CTRL_ABORT_EN
  assign abort_hit = bus.abort && state != IDLE;
`else
  assign abort_hit = 1'b0;
`endif
  assign run_end = state == RUN && bus.stage_done;
  assign clr = (state == IDLE && bus.start) || run_end || abort_hit;
  assign upd = bus.bw_act && !abort_hit && ((state == RUN && !bus.stage_done) || state == EVAL);
  assign peak_eff = bus.bw_act && bus.bw > peak ? bus.bw : peak;
  assign diff = peak_eff - HR;
  assign shift_nxt = peak_eff > HR ? (diff > MS ? MS : diff) : '0;
  assign exp_sum = {1'b0, bfp_exp} + (BFP_EXP_W + 1)'(shift_nxt);
  bfp_peak_track #(.W(FFT_BFPDW)) u_peak (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .upd(upd),
    .d(bus.bw),
    .q(peak)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next-state: one EVAL cycle per stage, DONE after the last stage
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.start ? RUN : IDLE;
      RUN: state_nxt = bus.stage_done ? EVAL : RUN;
      EVAL: state_nxt = stage_idx == LAST ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end
  // stage counter, registered shift and saturating exponent accumulator
  always_ff @(posedge clk)
    if (rst) begin
      stage_idx <= '0;
      shift <= '0;
      bfp_exp <= '0;
    end else if (abort_hit || (state == IDLE && bus.start)) begin
      stage_idx <= '0;
      bfp_exp <= '0;
    end else if (run_end) begin
      shift <= shift_nxt;
      bfp_exp <= exp_sum[BFP_EXP_W] ? '1 : exp_sum[BFP_EXP_W-1:0];
    end else if (state == EVAL && stage_idx != LAST) begin
      stage_idx <= stage_idx + 1'b1;
    end
  assign bus.busy = state != IDLE;
  assign bus.shift_vld = state == EVAL;
  assign bus.done = state == DONE;
  assign bus.stage_idx = stage_idx;
  assign bus.shift = shift;
  assign bus.bfp_exp = bfp_exp;
endmodule

// File: tb/tb_bfp_stage_ctrl.sv
// tb_bfp_stage_ctrl: directed checks of stage shifts, exponent accumulation, done timing and reset
module tb_bfp_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bfp_stage_ctrl_if #(.FFT_BFPDW(5), .FFT_N(3)) bus ();
  bfp_stage_ctrl #(.FFT_BFPDW(5), .FFT_DW(16), .FFT_N(3), .HEADROOM_BW(14), .MAX_SHIFT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    bus.start = 0;
    bus.stage_done = 0;
    bus.bw_act = 0;
    bus.bw = '0;
`ifdef BFP_STAGE_CTRL_ABORT_EN
    bus.abort = 0;
`endif
    tick;
    tick;
    rst = 0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_idx", 32'(bus.stage_idx), 0);
    chk("rst_exp", 32'(bus.bfp_exp), 0);
    chk("rst_shift", 32'(bus.shift), 0);
    chk("rst_vld", 32'(bus.shift_vld), 0);
    chk("rst_done", 32'(bus.done), 0);
    bus.stage_done = 1;
    tick;
    bus.stage_done = 0;
    chk("idle_sd_busy", 32'(bus.busy), 0);
    chk("idle_sd_vld", 32'(bus.shift_vld), 0);
    bus.start = 1;
    tick;
    bus.start = 0;
    chk("a_busy", 32'(bus.busy), 1);
    bus.bw_act = 1; bus.bw = 10;
    tick;
    bus.bw = 12;
    tick;
    bus.bw_act = 0; bus.stage_done = 1;
    tick;
    bus.stage_done = 0;
    chk("a0_vld", 32'(bus.shift_vld), 1);
    chk("a0_shift", 32'(bus.shift), 0);
    chk("a0_exp", 32'(bus.bfp_exp), 0);
    tick;
    chk("a0_vld_off", 32'(bus.shift_vld), 0);
    chk("a1_idx", 32'(bus.stage_idx), 1);
    bus.bw_act = 1; bus.bw = 15;
    tick;
    bus.bw_act = 0; bus.stage_done = 1;
    tick;
    bus.stage_done = 0;
    chk("a1_shift", 32'(bus.shift), 1);
    chk("a1_exp", 32'(bus.bfp_exp), 1);
    tick;
    bus.bw_act = 1; bus.bw = 17;
    tick;
    bus.bw_act = 0; bus.stage_done = 1;
    tick;
    bus.stage_done = 0;
    chk("a2_vld", 32'(bus.shift_vld), 1);
    chk("a2_shift", 32'(bus.shift), 2);
    chk("a2_exp", 32'(bus.bfp_exp), 3);
    chk("a2_done_early", 32'(bus.done), 0);
    bus.start = 1;
    tick;
    chk("a_done", 32'(bus.done), 1);
    chk("a_done_busy", 32'(bus.busy), 1);
    tick;
    bus.start = 0;
    chk("a_idle_busy", 32'(bus.busy), 0);
    chk("a_idle_done", 32'(bus.done), 0);
    chk("a_hold_exp", 32'(bus.bfp_exp), 3);
    chk("a_hold_shift", 32'(bus.shift), 2);
    tick;
    chk("a_start_ignored", 32'(bus.busy), 0);
    bus.start = 1;
    tick;
    bus.start = 0;
    bus.bw_act = 1; bus.bw = 9;
    tick;
    bus.bw = 16; bus.stage_done = 1;
    tick;
    bus.stage_done = 0; bus.bw = 15;
    chk("b0_shift", 32'(bus.shift), 2);
    chk("b0_exp", 32'(bus.bfp_exp), 2);
    tick;
    bus.bw_act = 0; bus.stage_done = 1;
    tick;
    bus.stage_done = 0;
    chk("b1_eval_load_shift", 32'(bus.shift), 1);
    chk("b1_exp", 32'(bus.bfp_exp), 3);
    rst = 1;
    tick;
    rst = 0;
    bus.start = 1;
    tick;
    bus.start = 0; bus.stage_done = 1;
    tick;
    bus.stage_done = 0;
    chk("c0_shift", 32'(bus.shift), 0);
    tick;
    chk("c1_idx", 32'(bus.stage_idx), 1);
    bus.bw_act = 1; bus.bw = 20;
    tick;
    rst = 1; bus.start = 1; bus.stage_done = 1;
    tick;
    rst = 0; bus.start = 0; bus.stage_done = 0; bus.bw_act = 0;
    chk("c_rst_busy", 32'(bus.busy), 0);
    chk("c_rst_idx", 32'(bus.stage_idx), 0);
    chk("c_rst_exp", 32'(bus.bfp_exp), 0);
    chk("c_rst_vld", 32'(bus.shift_vld), 0);
    chk("c_rst_shift", 32'(bus.shift), 0);
`ifdef BFP_STAGE_CTRL_ABORT_EN
    bus.start = 1;
    tick;
    bus.start = 0; bus.bw_act = 1; bus.bw = 17; bus.stage_done = 1;
    tick;
    bus.stage_done = 0; bus.bw_act = 0;
    chk("d_eval_exp", 32'(bus.bfp_exp), 2);
    bus.abort = 1;
    tick;
    bus.abort = 0;
    chk("d_abort_busy", 32'(bus.busy), 0);
    chk("d_abort_exp", 32'(bus.bfp_exp), 0);
    chk("d_abort_done", 32'(bus.done), 0);
    tick;
    chk("d_abort_no_done", 32'(bus.done), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
